// File: rtl/palette_pkg.sv
// palette_pkg: shared scene, palette-select and sequencer-state types
// Imported by palette_scene_sequencer and rgb_fader.
package palette_pkg;
  typedef enum logic [1:0] {START = 2'd0, MAP = 2'd1, COLLISION = 2'd2} scene_e;
  typedef enum logic [1:0] {IDLE, FADE_OUT, SWAP, FADE_IN} seq_state_e;
  localparam logic [1:0] SEL_SPRITE    = 2'd0;
  localparam logic [1:0] SEL_MAP       = 2'd1;
  localparam logic [1:0] SEL_COLLISION = 2'd2;
  localparam logic [1:0] SEL_START     = 2'd3;
endpackage

// File: rtl/palette_scene_sequencer_rgb_fader.sv
// rgb_fader: combinational scaler, each 8-bit channel becomes (c * level) >> SHIFT
// Ports: color (24-bit {R,G,B}), level (0..2^SHIFT), faded (24-bit result).
module rgb_fader
  import palette_pkg::*;
#(
  parameter int SHIFT = 3
) (
  input  logic [23:0] color,
  input  logic [3:0]  level,
  output logic [23:0] faded
);
  for (genvar i = 0; i < 3; i++) begin : g_ch
    logic [11:0] prod;
    assign prod = {4'd0, color[8*i +: 8]} * {8'd0, level};
    assign faded[8*i +: 8] = 8'(prod >> SHIFT);
  end
endmodule

// File: rtl/palette_scene_sequencer.sv
// palette_scene_sequencer: per-pixel palette select, frame-aligned scene switching with fade, registered VGA colour
// Ports: Clk, Reset_n (sync, active low); frame_start, pixel_valid, sprite_hit, sprite_idx;
//   mode_req/mode_req_valid/mode_req_ready scene request handshake; select -> palette mux -> thecolor;
//   rgb/rgb_valid to VGA (2-cycle latency); scene, busy status.
// Build option: define PALETTE_FADE_EN for the fade-out/fade-in transition; without it scenes swap directly.
module palette_scene_sequencer
  import palette_pkg::*;
#(
  parameter int         FADE_STEPS      = 8,
  parameter int         STEP_FRAMES     = 2,
  parameter logic [3:0] TRANSPARENT_IDX = 4'd0
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_start,
  input  logic        pixel_valid,
  input  logic        sprite_hit,
  input  logic [3:0]  sprite_idx,
  input  logic [1:0]  mode_req,
  input  logic        mode_req_valid,
  output logic        mode_req_ready,
  output logic [1:0]  select,
  input  logic [23:0] thecolor,
  output logic [23:0] rgb,
  output logic        rgb_valid,
  output logic [1:0]  scene,
  output logic        busy
);
  if (FADE_STEPS < 2 || FADE_STEPS > 8 || (FADE_STEPS & (FADE_STEPS - 1)) != 0 ||
      STEP_FRAMES < 1 || STEP_FRAMES > 15) begin : g_bad_params
    $error("palette_scene_sequencer: FADE_STEPS or STEP_FRAMES out of range");
  end
  seq_state_e  state;
  logic [1:0]  pending;
  logic        pv_d;
  logic [23:0] faded;
  assign mode_req_ready = state == IDLE;
  assign busy = state != IDLE;
`ifdef PALETTE_FADE_EN
  localparam logic [3:0] FULL      = 4'(FADE_STEPS);
  localparam logic [3:0] STEP_LAST = 4'(STEP_FRAMES - 1);
  logic [3:0] level, frame_cnt;
  logic       step_done;
  assign step_done = frame_start && frame_cnt == STEP_LAST;
  // Scene and level only move on frame_start, so nothing changes mid-frame.
  always_ff @(posedge Clk)
    if (!Reset_n) begin
      state <= IDLE;
      pending <= START;
      scene <= START;
      level <= FULL;
      frame_cnt <= '0;
    end else case (state)
      IDLE: if (mode_req_valid) begin
        pending <= mode_req;
        if (mode_req != scene && mode_req != 2'd3) begin
          state <= FADE_OUT;
          frame_cnt <= '0;
        end
      end
      FADE_OUT: if (frame_start) begin
        frame_cnt <= step_done ? '0 : frame_cnt + 4'd1;
        if (step_done) begin
          level <= level - 4'd1;
          if (level == 4'd1) state <= SWAP;
        end
      end
      SWAP: if (frame_start) begin
        scene <= pending;
        frame_cnt <= '0;
        state <= FADE_IN;
      end
      FADE_IN: if (frame_start) begin
        frame_cnt <= step_done ? '0 : frame_cnt + 4'd1;
        if (step_done) begin
          level <= level + 4'd1;
          if (level == FULL - 4'd1) state <= IDLE;
        end
      end
      default: state <= IDLE;
    endcase
  rgb_fader #(.SHIFT($clog2(FADE_STEPS))) u_fader (
    .color(thecolor),
    .level(level),
    .faded(faded)
  );
`else
  always_ff @(posedge Clk)
    if (!Reset_n) begin
      state <= IDLE;
      pending <= START;
      scene <= START;
    end else case (state)
      IDLE: if (mode_req_valid) begin
        pending <= mode_req;
        if (mode_req != scene && mode_req != 2'd3) state <= SWAP;
      end
      SWAP: if (frame_start) begin
        scene <= pending;
        state <= IDLE;
      end
      default: state <= IDLE;
    endcase
  assign faded = thecolor;
`endif
  // Stage 1 registers select (thecolor follows it combinationally); stage 2 registers the faded colour.
  always_ff @(posedge Clk)
    if (!Reset_n) begin
      select <= SEL_START;
      pv_d <= 1'b0;
      rgb_valid <= 1'b0;
      rgb <= '0;
    end else begin
      select <= scene == START ? SEL_START :
                (sprite_hit && sprite_idx != TRANSPARENT_IDX) ? SEL_SPRITE :
                scene == MAP ? SEL_MAP : SEL_COLLISION;
      pv_d <= pixel_valid;
      rgb_valid <= pv_d;
      rgb <= faded;
    end
endmodule

// File: tb/tb_palette_scene_sequencer.sv
// tb_palette_scene_sequencer: randomized self-checking bench with a pulse-count reference model
module tb_palette_scene_sequencer;
  localparam int FS = 8;
  localparam int SF = 2;
`ifdef PALETTE_FADE_EN
  localparam int HALF = FS * SF;
  localparam int TOTAL = 2 * FS * SF + 1;
  localparam int SWAPK = FS * SF + 1;
`else
  localparam int HALF = 0;
  localparam int TOTAL = 1;
  localparam int SWAPK = 1;
`endif
  logic Clk = 0, Reset_n = 0, frame_start = 0, pixel_valid = 0, sprite_hit = 0, mode_req_valid = 0;
  logic [3:0] sprite_idx = 0;
  logic [1:0] mode_req = 0;
  logic mode_req_ready, rgb_valid, busy;
  logic [1:0] select, scene;
  logic [23:0] thecolor, rgb;
  logic [23:0] pal [4];
  int nvec = 0, nerr = 0;
  bit in_tr = 0;
  int k = 0, e_lvl = FS;
  logic [1:0] m_scene = 0, tgt = 0, p_sel = 3, e_sel = 3;
  logic p_pv = 0, e_valid = 0;
  logic [23:0] e_rgb = 0;

  always #5 Clk = ~Clk;
  assign thecolor = pal[select];

  palette_scene_sequencer #(.FADE_STEPS(FS), .STEP_FRAMES(SF), .TRANSPARENT_IDX(4'd0)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .pixel_valid(pixel_valid),
    .sprite_hit(sprite_hit), .sprite_idx(sprite_idx), .mode_req(mode_req),
    .mode_req_valid(mode_req_valid), .mode_req_ready(mode_req_ready), .select(select),
    .thecolor(thecolor), .rgb(rgb), .rgb_valid(rgb_valid), .scene(scene), .busy(busy)
  );

  // Brightness as a function of pulses counted since the request was accepted.
  function automatic int cur_level();
    if (!in_tr) return FS;
    return k <= HALF ? FS - k / SF : (k - HALF - 1) / SF;
  endfunction

  function automatic logic [1:0] disp_scene();
    return (in_tr && k >= SWAPK) ? tgt : m_scene;
  endfunction

  function automatic logic [23:0] fade(logic [23:0] c, int l);
    logic [23:0] r;
    for (int i = 0; i < 3; i++) r[8*i +: 8] = 8'((int'(c[8*i +: 8]) * l) / FS);
    return r;
  endfunction

  task automatic rnd_pix();
    sprite_hit = 1'($urandom_range(0, 1));
    sprite_idx = 4'($urandom_range(0, 15));
    pixel_valid = 1'($urandom_range(0, 1));
  endtask

  task automatic rnd_pal();
    for (int i = 0; i < 4; i++) pal[i] = 24'($urandom);
  endtask

  // Advance one clock: predict outputs of the coming edge, then update the scene model.
  task automatic tick();
    logic [1:0] ds;
    ds = disp_scene();
    e_lvl = cur_level();
    if (!Reset_n) begin
      e_sel = 2'd3;
      e_rgb = '0;
      e_valid = 1'b0;
    end else begin
      e_sel = ds == 2'd0 ? 2'd3 : (sprite_hit && sprite_idx != 4'd0) ? 2'd0 : ds == 2'd1 ? 2'd1 : 2'd2;
      e_rgb = fade(pal[p_sel], e_lvl);
      e_valid = p_pv;
    end
    @(posedge Clk);
    if (!Reset_n) begin
      in_tr = 0;
      m_scene = 2'd0;
    end else if (!in_tr) begin
      if (mode_req_valid && mode_req != m_scene && mode_req != 2'd3) begin
        in_tr = 1;
        k = 0;
        tgt = mode_req;
      end
    end else if (frame_start) begin
      k++;
      if (k == TOTAL) begin
        in_tr = 0;
        m_scene = tgt;
      end
    end
    p_sel = e_sel;
    p_pv = Reset_n && pixel_valid;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset_n = 0;
    mode_req = 2'd1;
    mode_req_valid = 1;
    frame_start = 1;
    repeat (3) begin rnd_pix(); tick(); end
    nvec++; if (select !== 2'd3) begin nerr++; $display("FAIL reset_select: got %0d want 3", select); end
    nvec++; if (rgb !== 24'd0) begin nerr++; $display("FAIL reset_rgb: got %h want 0", rgb); end
    nvec++; if (rgb_valid !== 1'b0) begin nerr++; $display("FAIL reset_rgb_valid: got %b want 0", rgb_valid); end
    nvec++; if (scene !== 2'd0) begin nerr++; $display("FAIL reset_scene: got %0d want 0", scene); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", busy); end
    Reset_n = 1;
    mode_req_valid = 0;
    frame_start = 0;
    rnd_pix();
    tick();
    nvec++; if (mode_req_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready: got %b want 1", mode_req_ready); end
    nvec++; if (select !== e_sel) begin nerr++; $display("FAIL reset_select_after: got %0d want %0d", select, e_sel); end
  endtask

  task automatic test_transition();
    rnd_pal();
    mode_req = 2'd1;
    mode_req_valid = 1;
    rnd_pix();
    tick();
    mode_req_valid = 0;
    nvec++; if (busy !== 1'b1 || mode_req_ready !== 1'b0) begin nerr++; $display("FAIL accept: got busy=%b ready=%b want busy=1 ready=0", busy, mode_req_ready); end
    for (int p = 1; p <= TOTAL; p++) begin
      frame_start = 1;
      rnd_pix();
      tick();
      frame_start = 0;
      nvec++; if (busy !== (p < TOTAL)) begin nerr++; $display("FAIL busy_pulse p=%0d: got %b want %b", p, busy, p < TOTAL); end
      nvec++; if (scene !== (p >= SWAPK ? 2'd1 : 2'd0)) begin nerr++; $display("FAIL scene_pulse p=%0d: got %0d", p, scene); end
      nvec++; if (mode_req_ready !== (p >= TOTAL)) begin nerr++; $display("FAIL ready_pulse p=%0d: got %b", p, mode_req_ready); end
      rnd_pix();
      tick();
      nvec++; if (rgb !== e_rgb) begin nerr++; $display("FAIL rgb_transition p=%0d: got %h want %h", p, rgb, e_rgb); end
    end
  endtask

  task automatic test_select();
    sprite_hit = 1; sprite_idx = 4'd0; pixel_valid = 1;
    tick();
    nvec++; if (select !== 2'd1) begin nerr++; $display("FAIL select_transparent: got %0d want 1", select); end
    sprite_idx = 4'd5;
    tick();
    nvec++; if (select !== 2'd0) begin nerr++; $display("FAIL select_sprite: got %0d want 0", select); end
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 9) == 0) rnd_pal();
      frame_start = ($urandom_range(0, 7) == 0);
      rnd_pix();
      tick();
      nvec++; if (select !== e_sel) begin nerr++; $display("FAIL select_rand i=%0d: got %0d want %0d", i, select, e_sel); end
      nvec++; if (rgb !== e_rgb) begin nerr++; $display("FAIL rgb_rand i=%0d: got %h want %h", i, rgb, e_rgb); end
      nvec++; if (rgb_valid !== e_valid) begin nerr++; $display("FAIL rgb_valid_rand i=%0d: got %b want %b", i, rgb_valid, e_valid); end
      nvec++; if (scene !== 2'd1 || busy !== 1'b0) begin nerr++; $display("FAIL idle_frame i=%0d: got scene=%0d busy=%b want 1/0", i, scene, busy); end
    end
    frame_start = 0;
  endtask

  task automatic test_fade_math();
    for (int i = 0; i < 4; i++) pal[i] = 24'h0080ff;
    mode_req = 2'd2;
    mode_req_valid = 1;
    tick();
    mode_req_valid = 0;
    for (int p = 1; p <= TOTAL; p++) begin
      frame_start = 1;
      rnd_pix();
      tick();
      frame_start = 0;
      repeat (2) begin
        rnd_pix();
        tick();
        nvec++; if (rgb !== e_rgb) begin nerr++; $display("FAIL fade p=%0d lvl=%0d: got %h want %h", p, e_lvl, rgb, e_rgb); end
        if (e_lvl == 4 && FS == 8) begin
          nvec++; if (rgb !== 24'h00407f) begin nerr++; $display("FAIL fade_half: got %h want 00407f", rgb); end
        end
        if (e_lvl == 0) begin
          nvec++; if (rgb !== 24'h000000) begin nerr++; $display("FAIL fade_black: got %h want 000000", rgb); end
        end
      end
    end
    nvec++; if (scene !== 2'd2 || busy !== 1'b0) begin nerr++; $display("FAIL fade_end: got scene=%0d busy=%b want 2/0", scene, busy); end
  endtask

  task automatic test_busy_hold();
    mode_req = 2'd0;
    mode_req_valid = 1;
    tick();
    mode_req = 2'd1;
    repeat (4) begin
      tick();
      nvec++; if (mode_req_ready !== 1'b0 || busy !== 1'b1) begin nerr++; $display("FAIL hold_ready: got ready=%b busy=%b want 0/1", mode_req_ready, busy); end
    end
    for (int p = 1; p <= TOTAL; p++) begin
      mode_req_valid = (p <= HALF);
      frame_start = 1;
      tick();
      frame_start = 0;
      tick();
    end
    mode_req_valid = 0;
    nvec++; if (scene !== 2'd0 || busy !== 1'b0) begin nerr++; $display("FAIL hold_end: got scene=%0d busy=%b want 0/0", scene, busy); end
    mode_req = 2'd0;
    mode_req_valid = 1;
    tick();
    mode_req_valid = 0;
    tick();
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL same_scene: got busy=%b want 0", busy); end
    mode_req = 2'd3;
    mode_req_valid = 1;
    tick();
    mode_req_valid = 0;
    tick();
    nvec++; if (busy !== 1'b0 || scene !== 2'd0) begin nerr++; $display("FAIL reserved_req: got busy=%b scene=%0d want 0/0", busy, scene); end
  endtask

  task automatic test_back_to_back();
    mode_req = 2'd2;
    mode_req_valid = 1;
    frame_start = 1;
    tick();
    mode_req_valid = 0;
    frame_start = 0;
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL b2b_accept: got busy=%b want 1", busy); end
    for (int p = 1; p < TOTAL; p++) begin
      frame_start = 1;
      tick();
      frame_start = 0;
      tick();
    end
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL b2b_uncounted: got busy=%b want 1", busy); end
    frame_start = 1;
    tick();
    frame_start = 0;
    nvec++; if (busy !== 1'b0 || scene !== 2'd2) begin nerr++; $display("FAIL b2b_done: got busy=%b scene=%0d want 0/2", busy, scene); end
  endtask

  task automatic test_reset_mid();
    int n;
    n = TOTAL - 1 < 10 ? TOTAL - 1 : 10;
    mode_req = 2'd1;
    mode_req_valid = 1;
    tick();
    mode_req_valid = 0;
    for (int p = 0; p < n; p++) begin
      frame_start = 1;
      tick();
      frame_start = 0;
      tick();
    end
    Reset_n = 0;
    tick();
    nvec++; if (busy !== 1'b0 || scene !== 2'd0) begin nerr++; $display("FAIL mid_reset: got busy=%b scene=%0d want 0/0", busy, scene); end
    Reset_n = 1;
    rnd_pal();
    repeat (3) begin rnd_pix(); tick(); end
    nvec++; if (rgb !== pal[3]) begin nerr++; $display("FAIL mid_reset_full: got %h want %h", rgb, pal[3]); end
    nvec++; if (mode_req_ready !== 1'b1) begin nerr++; $display("FAIL mid_reset_ready: got %b want 1", mode_req_ready); end
  endtask

  initial begin
    rnd_pal();
    test_reset();
    test_transition();
    test_select();
    test_fade_math();
    test_busy_hold();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
